// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Holds the clear-engine state encoding and the hardwired-zero address.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_N_READ = 2;
  localparam int ZERO_ADDR  = 0;

endpackage

// File: rtl/regfile_if.sv
// Write, read and bulk-clear signal bundle of the register file.
// master drives requests and addresses; slave is the register file.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_READ = DEF_N_READ
) ();

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_ready;
  logic [N_READ*ADDR_W-1:0] rd_addr;
  logic [N_READ*DATA_W-1:0] rd_data;
  logic                     clr_req;
  logic                     busy;
  logic                     clr_done;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_addr, clr_req,
    input  wr_ready, rd_data,
    input  busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_addr, clr_req,
    output wr_ready, rd_data,
    output busy, clr_done
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear engine: walks entries 1..DEPTH-1, zeroing one per cycle.
// Emits a one-cycle clr_done after the last entry is cleared.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST  = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    clr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          idx_d   = FIRST;
        end
      end
      SWEEP: begin
        clr_en = 1'b1;
        // Stop on the last entry so the index never wraps to 0
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = FIRST;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + FIRST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= FIRST;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == SWEEP);
  assign clr_done = done_q;
  assign clr_idx  = idx_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file, entry 0 hardwired to zero, with bulk clear.
// REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_READ = DEF_N_READ
) (
  input logic      clk,
  input logic      reset_n,
  regfile_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              busy;
  logic              clr_done;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_live;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (bus.clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_en   (clr_en),
    .clr_idx  (clr_idx)
  );

  assign bus.busy     = busy;
  assign bus.clr_done = clr_done;
  assign bus.wr_ready = !busy;

  assign wr_live = bus.wr_en && !busy && (bus.wr_addr != ZERO);

  // Writes are refused while sweeping, so the two never collide
  always_comb begin
    mem_d = mem_q;
    if (wr_live) mem_d[bus.wr_addr] = bus.wr_data;
    if (clr_en)  mem_d[clr_idx]     = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar k = 0; k < N_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rv = mem_q[ra];
      if (ra == ZERO) begin
        rv = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (wr_live && (ra == bus.wr_addr)) begin
        rv = bus.wr_data;
      end
`endif
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = rv;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param (N_READ=2, 32x32).
// Honours REGFILE_BYPASS_EN for same-cycle read expectations.
module tb_regfile_param;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } sb_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  sb_t  sb_q[$];
  logic [31:0] model [32];

  regfile_if #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR)) bus ();

  regfile_param #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .N_READ (NR)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rd_push(input string tag, input int port, input int a,
                         input logic [31:0] exp);
    sb_t e;
    bus.rd_addr[port*AW +: AW] = AW'(a);
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic rd_pop();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, bus.rd_data[e.port*DW +: DW], e.exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (a != 0) model[a] = d;
  endtask

  initial begin
    int  busy_cycles;
    int  done_seen;
    int  done_at;
    bit  stall_done;

    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    reset_n     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    bus.clr_req = 1'b0;

    repeat (2) @(negedge clk);
    rd_push("rst_rd5", 0, 5, 32'h0);
    #1;
    rd_pop();
    check("rst_wr_ready", 32'(bus.wr_ready), 32'h1);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.clr_done), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // zero register and plain write
    wr(0, 32'hDEADBEEF);
    rd_push("zero_p0", 0, 0, 32'h0);
    rd_push("zero_p1", 1, 0, 32'h0);
    #1;
    rd_pop();
    wr(5, 32'h12345678);
    rd_push("wr5_p0", 0, 5, model[5]);
    rd_push("wr5_p1", 1, 5, 32'h12345678);
    #1;
    rd_pop();

    // multi-port
    wr(3, 32'hA);
    wr(7, 32'hB);
    rd_push("mp_p0", 0, 3, 32'hA);
    rd_push("mp_p1", 1, 7, 32'hB);
    #1;
    rd_pop();

    // same-cycle write/read on addr 4
    wr(4, 32'h11);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(4);
    bus.wr_data = 32'h77;
    rd_push("byp_p0", 0, 4, BYP ? 32'h77 : 32'h11);
    rd_push("byp_p1", 1, 4, BYP ? 32'h77 : 32'h11);
    #1;
    rd_pop();
    @(negedge clk);
    model[4]    = 32'h77;
    bus.wr_addr = AW'(0);
    bus.wr_data = 32'hFFFF_FFFF;
    rd_push("byp_next", 0, 4, 32'h77);
    rd_push("byp_zero", 1, 0, 32'h0);
    #1;
    rd_pop();
    @(negedge clk);
    bus.wr_en = 1'b0;

    // fill then sweep
    for (int i = 1; i < 32; i++) wr(i, 32'hC0DE_0000 | 32'(i));
    for (int i = 1; i < 32; i++) begin
      rd_push($sformatf("fill_%0d", i), i % 2, i, model[i]);
      #1;
      rd_pop();
    end

    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(1);
    bus.wr_data = 32'hF00D;
    bus.clr_req = 1'b1;
    #1;
    check("clr_wr_ready", 32'(bus.wr_ready), 32'h1);
    model[1] = 32'hF00D;

    busy_cycles = 0;
    done_seen   = 0;
    done_at     = 0;
    stall_done  = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bus.clr_req = (n == 15);
      bus.wr_en   = (n >= 10) && !stall_done;
      bus.wr_addr = AW'(9);
      bus.wr_data = 32'h55;
      if (n == 1) rd_push("sw_wr1", 0, 1, model[1]);
      if (n == 5) begin
        rd_push("sw_mid2", 0, 2, 32'h0);
        rd_push("sw_mid30", 1, 30, model[30]);
      end
      if (n == 20) rd_push("stall_nocommit", 0, 9, 32'h0);
      #1;
      rd_pop();
      if (n == 1) check("sw_busy1", 32'(bus.busy), 32'h1);
      if (n == 10) check("stall_rdy", 32'(bus.wr_ready), 32'h0);
      if (bus.busy) busy_cycles++;
      if (bus.clr_done) begin
        done_seen++;
        done_at = n;
      end
      if (bus.wr_en && bus.wr_ready) stall_done = 1'b1;
    end
    bus.wr_en = 1'b0;
    check("sw_busy_cycles", 32'(busy_cycles), 32'd31);
    check("sw_done_count", 32'(done_seen), 32'd1);
    check("sw_done_at", 32'(done_at), 32'd32);
    check("sw_idle_after", 32'(bus.busy), 32'h0);

    for (int i = 0; i < 32; i++) model[i] = '0;
    model[9] = 32'h55;
    for (int i = 0; i < 16; i++) begin
      rd_push($sformatf("post_%0d", i), 0, i, model[i]);
      rd_push($sformatf("post_%0d", i + 16), 1, i + 16, model[i + 16]);
      #1;
      rd_pop();
    end

    // reset during sweep
    wr(20, 32'h2020);
    wr(25, 32'h2525);
    wr(31, 32'h3131);
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("ab_busy_pre", 32'(bus.busy), 32'h1);
    reset_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    rd_push("ab_rd25", 0, 25, model[25]);
    rd_push("ab_rd31", 1, 31, model[31]);
    #1;
    rd_pop();
    check("ab_busy", 32'(bus.busy), 32'h0);
    check("ab_done", 32'(bus.clr_done), 32'h0);
    @(negedge clk);
    reset_n   = 1'b1;
    done_seen = 0;
    busy_cycles = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (bus.clr_done) done_seen++;
      if (bus.busy) busy_cycles++;
    end
    check("ab_no_done", 32'(done_seen), 32'd0);
    check("ab_no_busy", 32'(busy_cycles), 32'd0);
    rd_push("ab_rd20", 0, 20, model[20]);
    rd_push("ab_rd9", 1, 9, model[9]);
    #1;
    rd_pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
